score_keeper: RTL and testbench

Game-side producer of the 16-bit BCD score word consumed by the four-digit seven-segment display driver.
- Accepts graded hit events from the judgement logic over a valid/ready handshake.
- Accumulates points digit-serially in BCD, saturating at 9999.
- Maintains a two-digit BCD combo count.
- `num` connects directly to the display's `num` input; no binary-to-BCD conversion is needed downstream.

---
 rtl/score_keeper_if.sv | 9 +
 rtl/score_keeper.sv | 127 ++++++++++++
 tb/tb_score_keeper.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - hit event handshake between judgement logic and score_keeper
interface score_keeper_if;
  logic       hit_valid;
  logic [1:0] hit_grade;
  logic       hit_ready;

  modport master (output hit_valid, output hit_grade, input hit_ready);
  modport slave  (input hit_valid, input hit_grade, output hit_ready);
endinterface

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - digit-serial BCD score accumulator with combo count for the 7-seg display
// Optional macro SCORE_KEEPER_COMBO_BONUS_EN: +1 point on non-miss hits once combo reaches 10.
module score_keeper #(
  parameter logic [3:0] PT_GOOD    = 4'd1,
  parameter logic [3:0] PT_GREAT   = 4'd2,
  parameter logic [3:0] PT_PERFECT = 4'd3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  score_keeper_if.slave        hit,
  output logic [15:0]          num,
  output logic [7:0]           combo,
  output logic                 sat
);

  typedef enum logic {IDLE, ADD} state_t;

  state_t      state, state_next;
  logic [4:0]  remaining, remaining_next;
  logic [15:0] num_next, num_inc;
  logic [7:0]  combo_next, combo_inc;
  logic [4:0]  pts, bonus;
  logic        ready_q, accept;

  function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign hit.hit_ready = ready_q;
  assign accept        = hit.hit_valid && ready_q;
  assign num_inc       = bcd_inc16(num);

  // Combo saturates at 99 rather than wrapping.
  always_comb begin
    combo_inc = combo;
    if (combo != 8'h99) begin
      if (combo[3:0] == 4'd9) combo_inc = {combo[7:4] + 4'd1, 4'd0};
      else                    combo_inc = {combo[7:4], combo[3:0] + 4'd1};
    end
  end

  always_comb begin
    pts = 5'd0;
    case (hit.hit_grade)
      2'd1:    pts = {1'b0, PT_GOOD};
      2'd2:    pts = {1'b0, PT_GREAT};
      2'd3:    pts = {1'b0, PT_PERFECT};
      default: pts = 5'd0;
    endcase
`ifdef SCORE_KEEPER_COMBO_BONUS_EN
    bonus = (combo_inc[7:4] != 4'd0) ? 5'd1 : 5'd0;
`else
    bonus = 5'd0;
`endif
  end

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    num_next       = num;
    combo_next     = combo;
    if (clear) begin
      state_next     = IDLE;
      remaining_next = 5'd0;
      num_next       = 16'h0000;
      combo_next     = 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (hit.hit_grade == 2'd0) begin
              combo_next = 8'h00;
            end else begin
              combo_next     = combo_inc;
              remaining_next = pts + bonus;
              state_next     = ADD;
            end
          end
        end
        ADD: begin
          // At 9999 the step still consumes a cycle so ADD length stays fixed.
          if (num != 16'h9999) num_next = num_inc;
          remaining_next = remaining - 5'd1;
          if (remaining == 5'd1) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= 5'd0;
      num       <= 16'h0000;
      combo     <= 8'h00;
      sat       <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      remaining <= remaining_next;
      num       <= num_next;
      combo     <= combo_next;
      sat       <= (num_next == 16'h9999);
      ready_q   <= (state_next == IDLE);
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - table-driven check of score_keeper handshake, BCD carry, saturation, clear and reset
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] num;
  logic [7:0]  combo;
  logic        sat;
  int          n_tests = 0;
  int          n_fail = 0;
  int          cc = 0;
  int          model = 0;

  score_keeper_if hif ();

  score_keeper dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .hit   (hif),
    .num   (num),
    .combo (combo),
    .sat   (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  grade;
    int          busy;
    logic [15:0] num;
    logic [7:0]  combo;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one event, hold it until accepted, then count cycles with hit_ready low.
  task automatic do_hit(input logic [1:0] g, output int busy);
    int w;
    w = 0;
    hif.hit_valid = 1'b1;
    hif.hit_grade = g;
    while (!hif.hit_ready && w < 50) begin
      w++;
      step();
    end
    step();
    hif.hit_valid = 1'b0;
    busy = 0;
    while (!hif.hit_ready && busy < 40) begin
      busy++;
      step();
    end
    if (w >= 50 || busy >= 40) check("handshake_timeout", 32'd1, 32'd0);
  endtask

  // Inserts a miss before combo would reach 10, keeping bonus out of the points.
  task automatic feed(input logic [1:0] g);
    int b;
    if (cc == 9) begin
      do_hit(2'd0, b);
      cc = 0;
    end
    do_hit(g, b);
    cc++;
    model += (g == 2'd3) ? 3 : (g == 2'd2) ? 2 : (g == 2'd1) ? 1 : 0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    cc = 0;
    model = 0;
  endtask

  function automatic logic [15:0] to_bcd(input int d);
    return {4'(d / 1000 % 10), 4'(d / 100 % 10), 4'(d / 10 % 10), 4'(d % 10)};
  endfunction

  initial begin
    int b;
    vecs[0] = '{2'd2, 2, 16'h0002, 8'h01};
    vecs[1] = '{2'd1, 1, 16'h0003, 8'h02};
    vecs[2] = '{2'd3, 3, 16'h0006, 8'h03};
    vecs[3] = '{2'd0, 0, 16'h0006, 8'h00};
    vecs[4] = '{2'd3, 3, 16'h0009, 8'h01};
    vecs[5] = '{2'd1, 1, 16'h0010, 8'h02};
    vecs[6] = '{2'd2, 2, 16'h0012, 8'h03};

    hif.hit_valid = 1'b0;
    hif.hit_grade = 2'd0;
    #12;
    check("reset_num", 32'(num), 32'h0);
    check("reset_combo", 32'(combo), 32'h0);
    check("reset_sat", 32'(sat), 32'h0);
    check("reset_ready", 32'(hif.hit_ready), 32'h1);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      do_hit(vecs[i].grade, b);
      check($sformatf("vec%0d_busy", i), 32'(b), 32'(vecs[i].busy));
      check($sformatf("vec%0d_num", i), 32'(num), 32'(vecs[i].num));
      check($sformatf("vec%0d_combo", i), 32'(combo), 32'(vecs[i].combo));
    end

    // 98 goods then a perfect: carries ripple through digits 0 and 1.
    do_clear();
    for (int i = 0; i < 98; i++) feed(2'd1);
    check("pre98_num", 32'(num), 32'h0098);
    do_hit(2'd3, b);
    check("ripple_num", 32'(num), 32'h0101);
    check("ripple_busy", 32'(b), 32'd3);
    check("ripple_combo", 32'(combo), 32'h09);

    // 9 goods then a miss, then an event held through ADD.
    do_clear();
    for (int i = 0; i < 9; i++) do_hit(2'd1, b);
    check("combo_09", 32'(combo), 32'h09);
    do_hit(2'd0, b);
    check("combo_miss", 32'(combo), 32'h00);
    check("miss_busy", 32'(b), 32'd0);
    hif.hit_valid = 1'b1;
    hif.hit_grade = 2'd2;
    step();
    hif.hit_grade = 2'd1;
    check("held_ready_low", 32'(hif.hit_ready), 32'h0);
    step();
    step();
    check("held_ready_back", 32'(hif.hit_ready), 32'h1);
    check("held_num_mid", 32'(num), 32'h0011);
    step();
    hif.hit_valid = 1'b0;
    check("held_accepted_combo", 32'(combo), 32'h02);
    check("held_accepted_ready", 32'(hif.hit_ready), 32'h0);
    step();
    check("held_num_final", 32'(num), 32'h0012);
    check("held_ready_final", 32'(hif.hit_ready), 32'h1);

    // Climb to 9998 then saturate.
    do_clear();
    while (9998 - model >= 3) feed(2'd3);
    while (model < 9998) feed(2'd1);
    check("pre_sat_num", 32'(num), 32'(to_bcd(9998)));
    check("pre_sat_sat", 32'(sat), 32'h0);
    if (cc == 9) begin
      do_hit(2'd0, b);
      cc = 0;
    end
    hif.hit_valid = 1'b1;
    hif.hit_grade = 2'd3;
    step();
    hif.hit_valid = 1'b0;
    step();
    check("sat_num_e1", 32'(num), 32'h9999);
    check("sat_flag_e1", 32'(sat), 32'h1);
    check("sat_ready_e1", 32'(hif.hit_ready), 32'h0);
    step();
    check("sat_ready_e2", 32'(hif.hit_ready), 32'h0);
    step();
    check("sat_ready_e3", 32'(hif.hit_ready), 32'h1);
    check("sat_hold_num", 32'(num), 32'h9999);
    do_hit(2'd1, b);
    check("sat_extra_busy", 32'(b), 32'd1);
    check("sat_extra_num", 32'(num), 32'h9999);
    check("sat_extra_flag", 32'(sat), 32'h1);

    // Ten consecutive goods: only the tenth can earn the bonus.
    do_clear();
    check("clear_sat", 32'(sat), 32'h0);
    for (int i = 0; i < 10; i++) do_hit(2'd1, b);
    check("ten_combo", 32'(combo), 32'h10);
`ifdef SCORE_KEEPER_COMBO_BONUS_EN
    check("ten_num", 32'(num), 32'h0011);
`else
    check("ten_num", 32'(num), 32'h0010);
`endif

    // clear on the same edge as an accept wins.
    hif.hit_valid = 1'b1;
    hif.hit_grade = 2'd3;
    clear = 1'b1;
    step();
    clear = 1'b0;
    hif.hit_valid = 1'b0;
    check("clracc_num", 32'(num), 32'h0);
    check("clracc_combo", 32'(combo), 32'h0);
    check("clracc_ready", 32'(hif.hit_ready), 32'h1);
    step();
    check("clracc_ready2", 32'(hif.hit_ready), 32'h1);
    check("clracc_num2", 32'(num), 32'h0);

    // Asynchronous reset in the middle of ADD.
    hif.hit_valid = 1'b1;
    hif.hit_grade = 2'd3;
    step();
    hif.hit_valid = 1'b0;
    step();
    check("pre_rst_num", 32'(num), 32'h0001);
    #2;
    rst = 1'b1;
    #1;
    check("rst_num", 32'(num), 32'h0);
    check("rst_combo", 32'(combo), 32'h0);
    check("rst_ready", 32'(hif.hit_ready), 32'h1);
    #2;
    rst = 1'b0;
    step();
    step();
    check("post_rst_num", 32'(num), 32'h0);
    check("post_rst_ready", 32'(hif.hit_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
